noc_inject_arbiter: RTL and testbench

- Shares a node's single router injection port between NREQ local packet sources, e.g. the traffic generator, the receiver's reply path and a debug source.
- Sits between the local sources and the router's inject/inj/inject-ack interface.
- Round-robin selection; one packet in flight at a time.
- The chosen packet is captured into a holding register and presented until the router accepts it.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_inject_arbiter_if.sv | 28 ++
 rtl/noc_inject_arbiter_rr_picker.sv | 29 ++
 rtl/noc_inject_arbiter.sv | 117 +++++++++++
 tb/tb_noc_inject_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, mesh radix, flit type and the
// injection-arbiter state encoding.
package noc_pkg;

  localparam int LL = 16;  // flit width in bits
  localparam int MM = 4;   // mesh radix (routers per row/column)

  typedef logic [LL-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } arb_state_t;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Local-source and router-inject signal bundle for the injection arbiter.
// slave = arbiter side, master = sources plus router side.
interface noc_inject_arbiter_if #(
  parameter int LL   = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]    req;
  logic [NREQ*LL-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic [LL-1:0]      inject;
  logic               inj;
  logic               inj_ack;
  logic               busy;
  logic [IDW-1:0]     grant_id;

  modport slave (
    input  req, req_data, inj_ack,
    output req_ack, inject, inj, busy, grant_id
  );

  modport master (
    output req, req_data, inj_ack,
    input  req_ack, inject, inj, busy, grant_id
  );

endinterface

// File: rtl/noc_inject_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping NREQ-1 -> 0. Shared with router output-port arbitration.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  winner
);

  int idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter: one packet held and offered to the router at
// a time. Optional grant counters under NOC_INJ_ARB_STATS_EN.
module noc_inject_arbiter #(
  parameter int LL   = noc_pkg::LL,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  noc_inject_arbiter_if.slave    bus,
  input  logic [IDW-1:0]         stat_sel,
  output logic [15:0]            stat_count
);
  import noc_pkg::*;

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [LL-1:0]   pkt_q, pkt_d;
  logic            inj_q, inj_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic [LL-1:0]   slot [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = bus.req_data[i*LL +: LL];
  end

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .winner (pick_id)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    pkt_d   = pkt_q;
    inj_d   = inj_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          pkt_d   = slot[pick_id];
          gid_d   = pick_id;
          inj_d   = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Held packet is frozen here; only the router ack moves us on.
        if (bus.inj_ack) begin
          inj_d        = 1'b0;
          ack_d[gid_q] = 1'b1;
          ptr_d        = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
          state_d      = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      pkt_q   <= '0;
      inj_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      pkt_q   <= pkt_d;
      inj_q   <= inj_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.inject   = pkt_q;
  assign bus.inj      = inj_q;
  assign bus.req_ack  = ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state_q != IDLE);

`ifdef NOC_INJ_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // Counted from ack_d so the count moves on the same edge the pulse appears.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else if (ack_d[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign stat_count = cnt_q[stat_sel];
`else
  logic unused_stat_sel;

  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = 16'd0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter with a behavioural model checked every
// cycle plus hand-computed literal expectations.
module tb_noc_inject_arbiter;

  localparam int LL   = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [IDW-1:0] stat_sel = '0;
  logic [15:0]    stat_count;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  noc_inject_arbiter_if #(.LL(LL), .NREQ(NREQ), .IDW(IDW)) bus ();

  noc_inject_arbiter #(.LL(LL), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a packet is either held, in its one-cycle gap, or
  // absent; the next pick is the first pending requester from the pointer.
  bit          m_hold = 0;
  bit          m_gap  = 0;
  int          m_ptr  = 0;
  int          m_gid  = 0;
  logic [15:0] m_pkt  = '0;
  logic [3:0]  m_ack  = '0;
  int          m_cnt [NREQ] = '{default: 0};

  function automatic int first_pending(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = first_pending(bus.req, m_ptr);
    m_ack <= '0;
    if (reset) begin
      m_hold <= 0; m_gap <= 0; m_ptr <= 0; m_gid <= 0; m_pkt <= '0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] <= 0;
    end else if (m_gap) begin
      m_gap <= 0;
    end else if (m_hold) begin
      if (bus.inj_ack) begin
        m_hold <= 0;
        m_gap  <= 1;
        m_ack  <= 4'(1 << m_gid);
        m_ptr  <= (m_gid + 1) % NREQ;
        if (m_cnt[m_gid] < 65535) m_cnt[m_gid] <= m_cnt[m_gid] + 1;
      end
    end else if (w >= 0) begin
      m_hold <= 1;
      m_gid  <= w;
      m_pkt  <= bus.req_data[w*LL +: LL];
    end
  end

  always @(negedge clk) begin
    chk("mdl_inj",     32'(bus.inj),      32'(m_hold));
    chk("mdl_busy",    32'(bus.busy),     32'(m_hold | m_gap));
    chk("mdl_inject",  32'(bus.inject),   32'(m_pkt));
    chk("mdl_grant",   32'(bus.grant_id), 32'(m_gid));
    chk("mdl_req_ack", 32'(bus.req_ack),  32'(m_ack));
`ifdef NOC_INJ_ARB_STATS_EN
    chk("mdl_stat",    32'(stat_count),   32'(m_cnt[stat_sel]));
`else
    chk("mdl_stat",    32'(stat_count),   32'd0);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    bus.req_data[i*LL +: LL] = v;
  endtask

  task automatic wait_inj(input string name);
    int t;
    t = 0;
    while (!bus.inj && t < 20) begin
      cyc(1);
      t++;
    end
    if (!bus.inj) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  initial begin
    int last_rise;
    bus.req      = '0;
    bus.req_data = '0;
    bus.inj_ack  = 1'b0;
    cyc(2);

    // Reset state
    chk("rst_inj",     32'(bus.inj),      32'd0);
    chk("rst_busy",    32'(bus.busy),     32'd0);
    chk("rst_grant",   32'(bus.grant_id), 32'd0);
    chk("rst_req_ack", 32'(bus.req_ack),  32'd0);
    chk("rst_inject",  32'(bus.inject),   32'd0);
    reset = 1'b0;

    // Single request from requester 2
    bus.req = 4'b0100;
    set_data(2, 16'hA5C3);
    cyc(1);
    chk("single_inj",    32'(bus.inj),      32'd1);
    chk("single_inject", 32'(bus.inject),   32'hA5C3);
    chk("single_grant",  32'(bus.grant_id), 32'd2);
    cyc(1);
    bus.inj_ack = 1'b1;
    cyc(1);
    bus.inj_ack = 1'b0;
    bus.req     = '0;
    chk("single_ack",     32'(bus.req_ack), 32'b0100);
    chk("single_inj_low", 32'(bus.inj),     32'd0);
    cyc(1);
    chk("single_ack_once", 32'(bus.req_ack), 32'd0);
    // Pointer now 3: with 0 and 3 pending, 3 wins
    bus.req = 4'b1001;
    set_data(0, 16'h1111);
    set_data(3, 16'h3333);
    cyc(1);
    chk("ptr3_grant",  32'(bus.grant_id), 32'd3);
    chk("ptr3_inject", 32'(bus.inject),   32'h3333);
    bus.inj_ack = 1'b1;
    cyc(1);
    bus.inj_ack = 1'b0;
    bus.req     = '0;
    cyc(2);

    // All four pending, ack the cycle after each offer
    do_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, 16'(16'h1000 * (i + 1)));
    bus.req   = 4'b1111;
    last_rise = 0;
    for (int g = 0; g < 5; g++) begin
      wait_inj("rr");
      chk("rr_grant",  32'(bus.grant_id), 32'(g % 4));
      chk("rr_inject", 32'(bus.inject),   32'(16'h1000 * ((g % 4) + 1)));
      if (g > 0) chk("rr_spacing", 32'(cyc_n - last_rise), 32'd3);
      last_rise   = cyc_n;
      bus.inj_ack = 1'b1;
      cyc(1);
      bus.inj_ack = 1'b0;
      if (g == 4) bus.req = '0;
    end
    cyc(2);

    // Backpressure: packet frozen while the source data keeps changing
    bus.req = 4'b0001;
    set_data(0, 16'hBEEF);
    cyc(1);
    for (int k = 0; k < 20; k++) begin
      set_data(0, 16'(16'h0100 + k));
      cyc(1);
      chk("bp_inject",  32'(bus.inject),  32'hBEEF);
      chk("bp_inj",     32'(bus.inj),     32'd1);
      chk("bp_req_ack", 32'(bus.req_ack), 32'd0);
    end
    bus.inj_ack = 1'b1;
    cyc(1);
    bus.inj_ack = 1'b0;
    bus.req     = '0;
    chk("bp_ack", 32'(bus.req_ack), 32'b0001);
    cyc(2);

    // Reset while offering requester 1's packet
    bus.req = 4'b0010;
    set_data(1, 16'h5A5A);
    cyc(1);
    chk("rmid_grant", 32'(bus.grant_id), 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rmid_inj",     32'(bus.inj),      32'd0);
    chk("rmid_req_ack", 32'(bus.req_ack),  32'd0);
    chk("rmid_grant0",  32'(bus.grant_id), 32'd0);
    cyc(1);
    chk("rmid_reserve", 32'(bus.grant_id), 32'd1);
    chk("rmid_inj2",    32'(bus.inj),      32'd1);
    bus.inj_ack = 1'b1;
    cyc(1);
    bus.inj_ack = 1'b0;
    bus.req     = '0;
    cyc(2);
    // Stray ack while idle is ignored
    bus.inj_ack = 1'b1;
    cyc(1);
    bus.inj_ack = 1'b0;
    chk("idle_ack_ignored", 32'(bus.req_ack), 32'd0);

    // Requester 3 withdraws during OFFER
    bus.req = 4'b1000;
    set_data(3, 16'hC0DE);
    cyc(1);
    bus.req = '0;
    cyc(2);
    chk("drop_inj",    32'(bus.inj),    32'd1);
    chk("drop_inject", 32'(bus.inject), 32'hC0DE);
    bus.inj_ack = 1'b1;
    cyc(1);
    bus.inj_ack = 1'b0;
    chk("drop_ack", 32'(bus.req_ack), 32'b1000);
    cyc(1);
    chk("drop_ack_once", 32'(bus.req_ack), 32'd0);
    cyc(2);

    // Five grants to requester 1, then read its counter
    do_reset();
    bus.req = 4'b0010;
    for (int g = 0; g < 5; g++) begin
      wait_inj("stat");
      bus.inj_ack = 1'b1;
      cyc(1);
      bus.inj_ack = 1'b0;
      if (g == 4) bus.req = '0;
    end
    stat_sel = 2'd1;
    cyc(2);
`ifdef NOC_INJ_ARB_STATS_EN
    chk("stat_req1", 32'(stat_count), 32'd5);
    stat_sel = 2'd0;
    cyc(1);
    chk("stat_req0", 32'(stat_count), 32'd0);
`else
    chk("stat_off", 32'(stat_count), 32'd0);
`endif
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
